alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 161 ++++++++++++++++
 tb/tb_alu_seq.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential execute-stage ALU: base integer ops in one registered cycle, RV32M
// multiply/divide on a shared shift-add / restoring-divide datapath.
module alu_seq #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       ALUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALURes
);

  localparam int CW = SHW + 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CALC, S_DONE} state_t;

  state_t             state_q;
  logic               busy_q, done_q;
  logic [WIDTH-1:0]   res_q;
  logic [4:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, m_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;
  logic               neg_lo_q, neg_hi_q;

  // Decode of the request as presented, used only on an accepted start.
  logic [2:0]       in_fn;
  logic             in_div, in_sdiv, in_special, in_sa, in_sb, in_a_neg, in_b_neg;
  logic [WIDTH-1:0] in_a_mag, in_b_mag;

  // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    in_fn      = ALUOp[2:0];
    in_div     = ALUOp[4] & in_fn[2];
    in_sdiv    = in_div & ~in_fn[0];
    in_special = in_div & ((B == '0) | (in_sdiv & (A == MIN_NEG) & (B == '1)));
    in_sa      = in_div ? in_sdiv : ((in_fn == 3'b001) || (in_fn == 3'b010));
    in_sb      = in_div ? in_sdiv : (in_fn == 3'b001);
    in_a_neg   = in_sa & A[WIDTH-1];
    in_b_neg   = in_sb & B[WIDTH-1];
    in_a_mag   = in_a_neg ? -A : A;
    in_b_mag   = in_b_neg ? -B : B;
  end

  // One iteration step and the final sign fix-up.
  logic [WIDTH:0]       mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0]   acc_d, prod_d;
  logic [WIDTH-1:0]     quo_d, rem_d, calc_res_d;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
    div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, m_q};
    if (op_q[2]) begin
      // Borrow out of the trial subtraction means the shifted remainder was smaller.
      acc_d = div_diff[WIDTH] ? {div_sh[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b0}
                              : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end
    prod_d = neg_lo_q ? -acc_q : acc_q;
    quo_d  = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_d  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    if (op_q[2])                calc_res_d = op_q[1] ? rem_d : quo_d;
    else if (op_q[1:0] == 2'b00) calc_res_d = prod_d[WIDTH-1:0];
    else                        calc_res_d = prod_d[2*WIDTH-1:WIDTH];
  end

  // Single-cycle results: base ops and the divide special cases.
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] base_res, spec_res, fast_res_d;

  always_comb begin
    shamt = b_q[SHW-1:0];
    case (op_q[3:0])
      4'b0000: base_res = a_q + b_q;
      4'b1000: base_res = a_q - b_q;
      4'b0001: base_res = a_q << shamt;
      4'b0010: base_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      4'b0011: base_res = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
      4'b0100: base_res = a_q ^ b_q;
      4'b0101: base_res = a_q >> shamt;
      4'b1101: base_res = $unsigned($signed(a_q) >>> shamt);
      4'b0110: base_res = a_q | b_q;
      4'b0111: base_res = a_q & b_q;
      4'b1001: base_res = b_q;
      default: base_res = '0;
    endcase
    if (b_q == '0) spec_res = op_q[1] ? a_q : '1;
    else           spec_res = op_q[1] ? '0 : a_q;
    fast_res_d = op_q[4] ? spec_res : base_res;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          busy_q <= start;
          if (start) begin
            // NOTE: operand and accumulator registers are never reset; they are
            // always loaded here before anything reads them.
            op_q     <= ALUOp;
            a_q      <= A;
            b_q      <= B;
            acc_q    <= {{WIDTH{1'b0}}, (in_div ? in_a_mag : in_b_mag)};
            m_q      <= in_div ? in_b_mag : in_a_mag;
            neg_lo_q <= in_a_neg ^ in_b_neg;
            neg_hi_q <= in_a_neg;
            if (ALUOp[4] && !in_special) begin
              cnt_q   <= CW'(WIDTH);
              state_q <= S_CALC;
            end else begin
              cnt_q   <= '0;
              state_q <= S_EXEC;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_EXEC: begin
          res_q   <= fast_res_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_DONE;
        end
        S_CALC: begin
          if (cnt_q == '0) begin
            res_q   <= calc_res_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign ALURes = res_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32 and WIDTH=16, checked every cycle
// against an arithmetic model of results and handshake timing.
module tb_alu_seq;

  localparam logic [4:0] ADD = 5'b00000, SUB = 5'b01000, SLL = 5'b00001, SLT = 5'b00010,
                         SLTU = 5'b00011, XORO = 5'b00100, SRL = 5'b00101, SRA = 5'b01101,
                         ORO = 5'b00110, ANDO = 5'b00111, PASSB = 5'b01001, BADOP = 5'b01010,
                         MUL = 5'b10000, MULH = 5'b10001, MULHSU = 5'b10010, MULHU = 5'b10011,
                         DIV = 5'b10100, DIVU = 5'b10101, REM = 5'b10110, REMU = 5'b10111;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_r [2];
  logic [4:0]  op_r [2];
  logic [31:0] a_r [2];
  logic [31:0] b_r [2];
  logic        busy32, done32, busy16, done16;
  logic [31:0] res32;
  logic [15:0] res16;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  // Expected behaviour per instance: accept cycle, done cycle, pending and held result.
  int          st [2];
  int          dn [2];
  logic [63:0] pend [2];
  logic [63:0] held [2];

  alu_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start_r[0]), .ALUOp(op_r[0]), .A(a_r[0]), .B(b_r[0]),
    .busy(busy32), .done(done32), .ALURes(res32)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start_r[1]), .ALUOp(op_r[1]), .A(a_r[1][15:0]), .B(b_r[1][15:0]),
    .busy(busy16), .done(done16), .ALURes(res16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] msk(int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic longint sx(logic [63:0] x, int w);
    logic [63:0] m;
    m = msk(w);
    x = x & m;
    return x[w-1] ? longint'(x | ~m) : longint'(x);
  endfunction

  function automatic logic [63:0] model(logic [4:0] op, logic [63:0] a, logic [63:0] b, int w);
    logic [63:0] m, r;
    longint sa, sb;
    int sh;
    bit ovf;
    m  = msk(w);
    a  = a & m;
    b  = b & m;
    sa = sx(a, w);
    sb = sx(b, w);
    sh = int'(b[4:0]) & (w - 1);
    ovf = (sa == -(longint'(1) << (w - 1))) && (sb == -1);
    r = 64'd0;
    if (!op[4]) begin
      case (op[3:0])
        4'b0000: r = a + b;
        4'b1000: r = a - b;
        4'b0001: r = a << sh;
        4'b0010: r = (sa < sb) ? 64'd1 : 64'd0;
        4'b0011: r = (a < b) ? 64'd1 : 64'd0;
        4'b0100: r = a ^ b;
        4'b0101: r = a >> sh;
        4'b1101: r = 64'(sa >>> sh);
        4'b0110: r = a | b;
        4'b0111: r = a & b;
        4'b1001: r = b;
        default: r = 64'd0;
      endcase
    end else begin
      case (op[2:0])
        3'd0: r = a * b;
        3'd1: r = 64'(sa * sb) >> w;
        3'd2: r = 64'(sa * longint'(b)) >> w;
        3'd3: r = (a * b) >> w;
        3'd4: r = (b == 0) ? m : (ovf ? a : 64'(sa / sb));
        3'd5: r = (b == 0) ? m : a / b;
        3'd6: r = (b == 0) ? a : (ovf ? 64'd0 : 64'(sa % sb));
        default: r = (b == 0) ? a : a % b;
      endcase
    end
    return r & m;
  endfunction

  function automatic int lat(logic [4:0] op, logic [63:0] a, logic [63:0] b, int w);
    longint sa, sb;
    sa = sx(a, w);
    sb = sx(b, w);
    if (!op[4]) return 2;
    if (op[2] && (((b & msk(w)) == 0) ||
                  (!op[0] && sa == -(longint'(1) << (w - 1)) && sb == -1))) return 2;
    return w + 2;
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      st[k] = -10; dn[k] = -5; pend[k] = 64'd0; held[k] = 64'd0;
    end
  endtask

  // Hold start until the model says the request was taken (idle or done cycle).
  task automatic issue(int k, logic [4:0] op, logic [31:0] a, logic [31:0] b);
    int c;
    bit ok;
    int w;
    w  = (k == 1) ? 16 : 32;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      start_r[k] = 1'b1; op_r[k] = op; a_r[k] = a; b_r[k] = b;
      c = cyc;
      tick();
      if (c >= dn[k]) begin
        held[k] = pend[k];
        st[k]   = c;
        dn[k]   = c + lat(op, 64'(a), 64'(b), w);
        pend[k] = model(op, 64'(a), 64'(b), w);
        ok      = 1'b1;
      end
    end
    start_r[k] = 1'b0;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL issue_timeout: op %b never accepted", op);
    end
  endtask

  // A one-cycle start that must be ignored because the instance is busy.
  task automatic poke(int k, logic [4:0] op, logic [31:0] a, logic [31:0] b);
    start_r[k] = 1'b1; op_r[k] = op; a_r[k] = a; b_r[k] = b;
    tick();
    start_r[k] = 1'b0;
  endtask

  task automatic wait_check(int k, string name, logic [63:0] exp);
    int n;
    n = 0;
    while (cyc < dn[k] && n < 200) begin
      tick();
      n++;
    end
    if (cyc != dn[k]) begin
      tests++; fails++;
      $display("FAIL %s: no done by cycle %0d, required at %0d", name, cyc, dn[k]);
    end else begin
      check({name, "_res"}, (k == 1) ? {48'd0, res16} : {32'd0, res32}, exp);
      check({name, "_done"}, 64'((k == 1) ? done16 : done32), 64'd1);
    end
  endtask

  task automatic run_lit(int k, string name, logic [4:0] op, logic [31:0] a, logic [31:0] b,
                         logic [63:0] exp);
    issue(k, op, a, b);
    wait_check(k, name, exp);
  endtask

  task automatic pin(string name, logic [4:0] op, logic [31:0] a, logic [31:0] b, int w,
                     logic [63:0] exp);
    check({"model_", name}, model(op, 64'(a), 64'(b), w), exp);
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin : mon
    logic [63:0] got_res, e_res;
    logic        got_busy, got_done;
    string       tag;
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        got_res  = (k == 1) ? {48'd0, res16} : {32'd0, res32};
        got_busy = (k == 1) ? busy16 : busy32;
        got_done = (k == 1) ? done16 : done32;
        e_res    = (cyc >= dn[k]) ? pend[k] : held[k];
        tag      = (k == 1) ? "w16" : "w32";
        check({tag, "_busy"}, 64'(got_busy), 64'((st[k] < cyc) && (cyc < dn[k])));
        check({tag, "_done"}, 64'(got_done), 64'(cyc == dn[k]));
        check({tag, "_res"},  got_res, e_res);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start_r[k] = 1'b0; op_r[k] = 5'd0; a_r[k] = 32'd0; b_r[k] = 32'd0;
    end
    model_reset();
    repeat (2) tick();
    rst = 1'b0;
    mon_en = 1'b1;
    check("reset_busy32", 64'(busy32), 64'd0);
    check("reset_done32", 64'(done32), 64'd0);
    check("reset_res32", 64'(res32), 64'd0);
    check("reset_res16", 64'(res16), 64'd0);

    // Hand-computed values pinning the model.
    pin("add",    ADD,    32'hF,        32'hA,        32, 64'h19);
    pin("sra",    SRA,    32'hFFFFFFF0, 32'h2,        32, 64'hFFFFFFFC);
    pin("sltu",   SLTU,   32'hFFFFFFFF, 32'hA,        32, 64'h0);
    pin("sll",    SLL,    32'h3,        32'h22,       32, 64'hC);
    pin("mul",    MUL,    32'hFFFFFFFF, 32'h2,        32, 64'hFFFFFFFE);
    pin("mulh",   MULH,   32'hFFFFFFFE, 32'h3,        32, 64'hFFFFFFFF);
    pin("mulhu",  MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32, 64'hFFFFFFFE);
    pin("mulhsu", MULHSU, 32'hFFFFFFFF, 32'h2,        32, 64'hFFFFFFFF);
    pin("div",    DIV,    32'hFFFFFFF9, 32'h2,        32, 64'hFFFFFFFD);
    pin("rem",    REM,    32'hFFFFFFF9, 32'h2,        32, 64'hFFFFFFFF);
    pin("divz",   DIV,    32'h5,        32'h0,        32, 64'hFFFFFFFF);
    pin("ovf",    DIV,    32'h80000000, 32'hFFFFFFFF, 32, 64'h80000000);
    pin("removf", REM,    32'h80000000, 32'hFFFFFFFF, 32, 64'h0);
    pin("mulhu16", MULHU, 32'hFFFF,     32'hFFFF,     16, 64'hFFFE);

    // Base operations.
    run_lit(0, "add",   ADD,   32'hF,        32'hA,      64'h19);
    run_lit(0, "sub",   SUB,   32'h5,        32'h7,      64'hFFFFFFFE);
    run_lit(0, "sll",   SLL,   32'h3,        32'h22,     64'hC);
    run_lit(0, "slt",   SLT,   32'hFFFFFFFF, 32'h1,      64'h1);
    run_lit(0, "sltu",  SLTU,  32'hFFFFFFFF, 32'hA,      64'h0);
    run_lit(0, "xor",   XORO,  32'hF0F0,     32'hFF00,   64'h0FF0);
    run_lit(0, "srl",   SRL,   32'h80000000, 32'h4,      64'h08000000);
    run_lit(0, "sra",   SRA,   32'hFFFFFFF0, 32'h2,      64'hFFFFFFFC);
    run_lit(0, "or",    ORO,   32'h0F,       32'hF0,     64'hFF);
    run_lit(0, "and",   ANDO,  32'hFF,       32'h3C,     64'h3C);
    run_lit(0, "passb", PASSB, 32'h1,        32'h1234,   64'h1234);
    run_lit(0, "badop", BADOP, 32'h77,       32'h11,     64'h0);

    // Multiply and divide.
    run_lit(0, "mul",    MUL,    32'hFFFFFFFF, 32'h2,        64'hFFFFFFFE);
    run_lit(0, "mulh",   MULH,   32'hFFFFFFFE, 32'h3,        64'hFFFFFFFF);
    run_lit(0, "mulhu",  MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE);
    run_lit(0, "mulhsu", MULHSU, 32'hFFFFFFFF, 32'h2,        64'hFFFFFFFF);
    run_lit(0, "mulhpp", MULH,   32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF);
    run_lit(0, "div",    DIV,    32'hFFFFFFF9, 32'h2,        64'hFFFFFFFD);
    run_lit(0, "rem",    REM,    32'hFFFFFFF9, 32'h2,        64'hFFFFFFFF);
    run_lit(0, "divu",   DIVU,   32'd100,      32'd7,        64'd14);
    run_lit(0, "remu",   REMU,   32'd100,      32'd7,        64'd2);
    run_lit(0, "divnn",  DIV,    32'hFFFFFFF9, 32'hFFFFFFFE, 64'h3);
    run_lit(0, "divpn",  DIV,    32'h7,        32'hFFFFFFFE, 64'hFFFFFFFD);
    run_lit(0, "rempn",  5'b11110, 32'h7,      32'hFFFFFFFE, 64'h1);

    // Divide special cases on the fast path.
    run_lit(0, "divz",   DIV,  32'h5,        32'h0,        64'hFFFFFFFF);
    run_lit(0, "remuz",  REMU, 32'h5,        32'h0,        64'h5);
    run_lit(0, "divuz",  DIVU, 32'h5,        32'h0,        64'hFFFFFFFF);
    run_lit(0, "remz",   REM,  32'h5,        32'h0,        64'h5);
    run_lit(0, "divovf", DIV,  32'h80000000, 32'hFFFFFFFF, 64'h80000000);
    run_lit(0, "removf", REM,  32'h80000000, 32'hFFFFFFFF, 64'h0);

    // Start during CALC with other operands is ignored.
    issue(0, MUL, 32'd7, 32'd9);
    repeat (5) tick();
    poke(0, ADD, 32'd100, 32'd200);
    wait_check(0, "ignored", 64'd63);

    // Back-to-back base ops and a start held through a long multiply.
    issue(0, ADD, 32'd1, 32'd2);
    issue(0, SUB, 32'd10, 32'd3);
    issue(0, XORO, 32'd6, 32'd3);
    wait_check(0, "b2b", 64'd5);
    issue(0, MUL, 32'd3, 32'd5);
    issue(0, ADD, 32'd1, 32'd1);
    wait_check(0, "held", 64'd2);

    // Reset in the middle of a multiply.
    issue(0, MUL, 32'd7, 32'd9);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check("rstmid_busy", 64'(busy32), 64'd0);
    check("rstmid_done", 64'(done32), 64'd0);
    check("rstmid_res", 64'(res32), 64'd0);
    run_lit(0, "after_rst", ADD, 32'd1, 32'd1, 64'd2);

    // Reset wins over a simultaneous start.
    start_r[0] = 1'b1; op_r[0] = ADD; a_r[0] = 32'd5; b_r[0] = 32'd5;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start_r[0] = 1'b0;
    model_reset();
    check("rst_vs_start_busy", 64'(busy32), 64'd0);
    check("rst_vs_start_res", 64'(res32), 64'd0);

    // WIDTH=16 instance.
    run_lit(1, "mul16",    MUL,    32'hFFFF, 32'h2,    64'hFFFE);
    run_lit(1, "mulh16",   MULH,   32'hFFFE, 32'h3,    64'hFFFF);
    run_lit(1, "mulhu16",  MULHU,  32'hFFFF, 32'hFFFF, 64'hFFFE);
    run_lit(1, "mulhsu16", MULHSU, 32'hFFFF, 32'h2,    64'hFFFF);
    run_lit(1, "div16",    DIV,    32'hFFF9, 32'h2,    64'hFFFD);
    run_lit(1, "divu16",   DIVU,   32'd100,  32'd7,    64'd14);
    run_lit(1, "sll16",    SLL,    32'h1,    32'h13,   64'h8);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
